// File: rtl/mem_if_unit.sv
// LC-3 memory interface unit: MAR/MDR, request/acknowledge handshake, MDR bus driver.
// Define MEMIF_TIMEOUT_EN to compile in the REQ watchdog, the ERR state and the sticky mem_err.
module mem_if_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        gate_mdr,
  input  logic [15:0] bus_in,
  output logic [15:0] bus_out,
  output logic        bus_drv,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int DATA_W = 16;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_if_unit: TIMEOUT must be in 1..65535");
  end

`ifdef MEMIF_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                we_q, we_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_ready_q, mem_ready_d;

  // Request/ready/we are computed for the state being entered, so they are registered outputs.
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    we_d        = we_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_ready_d = 1'b0;
`ifdef MEMIF_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (ld_mar) mar_d = bus_in;
        if (mio_en) begin
          we_d      = r_w;
          state_d   = REQ;
          mem_req_d = 1'b1;
          mem_we_d  = r_w;
`ifdef MEMIF_TIMEOUT_EN
          wd_d      = '0;
`endif
        end else if (ld_mdr) begin
          mdr_d = bus_in;
        end
      end
      REQ: begin
        // An ack always beats a simultaneous watchdog expiry.
        if (mem_ack) begin
          if (!we_q) mdr_d = mem_rdata;
          state_d     = DONE;
          mem_ready_d = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = we_q;
`ifdef MEMIF_TIMEOUT_EN
          if (int'(wd_q) < TIMEOUT) wd_d = wd_q + WD_W'(1);
          if (int'(wd_q) + 1 >= TIMEOUT) begin
            state_d     = ERR;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_ready_d = 1'b1;
          end
`endif
        end
      end
      DONE: state_d = IDLE;
`ifdef MEMIF_TIMEOUT_EN
      ERR: begin
        state_d = IDLE;
        err_d   = 1'b1;
        if (!we_q) mdr_d = '0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      we_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_ready_q <= 1'b0;
`ifdef MEMIF_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      we_q        <= we_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_ready_q <= mem_ready_d;
`ifdef MEMIF_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus_out   = gate_mdr ? mdr_q : '0;
  assign bus_drv   = gate_mdr;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_ready = mem_ready_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
`ifdef MEMIF_TIMEOUT_EN
  assign mem_err   = err_q;
`else
  assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_if_unit.sv
// Self-checking bench for mem_if_unit: directed plan steps plus randomized accesses
// checked against a transaction-level model of MAR, MDR and the sticky error flag.
module tb_mem_if_unit;

  localparam int T = 4;
`ifdef MEMIF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0, gate_mdr = 1'b0;
  logic [15:0] bus_in = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] bus_out, mem_addr, mem_wdata;
  logic        bus_drv, mem_ready, mem_err, mem_req, mem_we;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_mar = '0, m_mdr = '0;
  logic        m_err = 1'b0;

  mem_if_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en),
    .r_w(r_w), .gate_mdr(gate_mdr), .bus_in(bus_in), .bus_out(bus_out), .bus_drv(bus_drv),
    .mem_ready(mem_ready), .mem_err(mem_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    gate_mdr = 1'($urandom);
    #1;
    check({tag, "_req"},   mem_req,   1'b0);
    check({tag, "_rdy"},   mem_ready, 1'b0);
    check({tag, "_addr"},  mem_addr,  m_mar);
    check({tag, "_wdata"}, mem_wdata, m_mdr);
    check({tag, "_bus"},   bus_out,   gate_mdr ? m_mdr : 16'h0000);
    check({tag, "_drv"},   bus_drv,   gate_mdr);
    check({tag, "_err"},   mem_err,   m_err);
  endtask

  task automatic load_mar(input logic [15:0] v);
    ld_mar = 1'b1; bus_in = v;
    tick();
    ld_mar = 1'b0;
    m_mar = v;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    ld_mdr = 1'b1; bus_in = v;
    tick();
    ld_mdr = 1'b0;
    m_mdr = v;
  endtask

  // ack_k: REQ cycle (1-based) in which memory acks; 0 means no ack at all.
  task automatic access(input string tag, input bit rw, input int ack_k,
                        input logic [15:0] rdata, input bit poke);
    int  req_cycles;
    bit  timed_out;
    if (ack_k > 0 && (!TO_EN || ack_k <= T)) begin
      req_cycles = ack_k; timed_out = 1'b0;
    end else begin
      req_cycles = T; timed_out = 1'b1;
    end
    mio_en = 1'b1; r_w = rw;
    ld_mdr = poke; bus_in = 16'($urandom);
    tick();
    mio_en = 1'b0; ld_mdr = 1'b0; r_w = 1'($urandom);
    for (int k = 1; k <= req_cycles; k++) begin
      mem_ack   = (k == ack_k);
      mem_rdata = (k == ack_k) ? rdata : 16'($urandom);
      if (poke) begin
        ld_mar = 1'($urandom); ld_mdr = 1'($urandom); bus_in = 16'($urandom);
      end
      #1;
      check({tag, "_req_hi"}, mem_req,   1'b1);
      check({tag, "_we"},     mem_we,    rw);
      check({tag, "_raddr"},  mem_addr,  m_mar);
      check({tag, "_rwdata"}, mem_wdata, m_mdr);
      check({tag, "_rrdy"},   mem_ready, 1'b0);
      tick();
    end
    ld_mar = 1'b0; ld_mdr = 1'b0;
    // Ack during the ready cycle must be ignored.
    mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
    #1;
    check({tag, "_req_lo"}, mem_req,   1'b0);
    check({tag, "_ready"},  mem_ready, 1'b1);
    check({tag, "_perr"},   mem_err,   m_err);
    if (!timed_out) begin
      if (!rw) m_mdr = rdata;
      check({tag, "_mdr"}, mem_wdata, m_mdr);
    end
    tick();
    mem_ack = 1'b0;
    if (timed_out) begin
      m_err = 1'b1;
      if (!rw) m_mdr = 16'h0000;
    end
    check_idle({tag, "_post"});
  endtask

  initial begin
    // Reset state
    gate_mdr = 1'b1;
    #2;
    check("rst_req", mem_req, 1'b0);
    check("rst_bus", bus_out, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_rdy", mem_ready, 1'b0);
    check("rst_err", mem_err, 1'b0);
    check("rst_we", mem_we, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    check_idle("rst_idle");

    // Directed read, write, freeze
    load_mar(16'h3000);
    access("read", 1'b0, 3, 16'h1234, 1'b0);
    gate_mdr = 1'b1; #1;
    check("read_bus", bus_out, 16'h1234);

    load_mar(16'h4001);
    load_mdr(16'hBEEF);
    access("write", 1'b1, 1, 16'h7777, 1'b0);
    check("write_mdr_kept", mem_wdata, 16'hBEEF);

    access("freeze", 1'b0, 3, 16'h2468, 1'b1);

`ifdef MEMIF_TIMEOUT_EN
    load_mar(16'h5000);
    access("tie", 1'b0, T, 16'hC0DE, 1'b0);
    check("tie_err", mem_err, 1'b0);
    check("tie_mdr", mem_wdata, 16'hC0DE);

    load_mdr(16'hABCD);
    access("timeout", 1'b0, 0, 16'h0000, 1'b0);
    check("timeout_mdr", mem_wdata, 16'h0000);
    check("timeout_err", mem_err, 1'b1);
    access("after_to", 1'b1, 2, 16'h1111, 1'b0);
    check("sticky_err", mem_err, 1'b1);
`else
    access("long_wait", 1'b0, 3 * T, 16'h5A5A, 1'b0);
    check("no_err", mem_err, 1'b0);
`endif

    // Randomized accesses
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) load_mar(16'($urandom));
      if ($urandom_range(0, 1) == 1) load_mdr(16'($urandom));
      access("rand", 1'($urandom), int'($urandom_range(1, 6)), 16'($urandom),
             1'($urandom));
    end

    // Asynchronous reset in the middle of a request
    load_mar(16'h3000);
    mio_en = 1'b1; r_w = 1'b0;
    tick();
    mio_en = 1'b0;
    tick();
    check("mid_req_before", mem_req, 1'b1);
    gate_mdr = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_rdy", mem_ready, 1'b0);
    check("mid_rst_addr", mem_addr, 16'h0000);
    check("mid_rst_wdata", mem_wdata, 16'h0000);
    check("mid_rst_bus", bus_out, 16'h0000);
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_err", mem_err, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    tick();
    check_idle("after_rst");
    access("after_rst_wr", 1'b1, 2, 16'h0F0F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
